// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: sequences external INT/NMI requests into the
// multi-cycle processor at instruction boundaries. It holds the controller,
// pulses INA, captures the return PC and issues a one-cycle redirect.
// Optional build macro: NMI_NESTING_EN lets a pending NMI preempt the INT
// handler. The INT return address is then saved in a second EPC register.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | normal execution; requests are evaluated at boundaries
// ACK        | INA asserted for ACK_CYCLES cycles, controller held
// ENTER      | one-cycle take_irq redirect to the handler vector
// INT_SVC    | running INT handler; INT not accepted again
// NMI_SVC    | running NMI handler; everything else stays pending
// NMI_NEST   | NMI handler preempting INT handler (NMI_NESTING_EN only)
module interrupt_sequencer #(
  parameter logic [31:0] VEC_INT    = 32'h0000_0080,
  parameter logic [31:0] VEC_NMI    = 32'h0000_0100,
  parameter int          ACK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        INT,
  input  logic        NMI,
  input  logic        INTD,
  input  logic        instr_boundary,
  input  logic        eret,
  input  logic [31:0] pc_next,
  output logic        hold,
  output logic        take_irq,
  output logic [31:0] vector,
  output logic [31:0] epc,
  output logic        INA,
  output logic [1:0]  in_handler
);

  localparam int CW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [CW-1:0] ACK_LOAD = CW'(ACK_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ACK      = 3'd1;
  localparam logic [2:0] S_ENTER    = 3'd2;
  localparam logic [2:0] S_INT_SVC  = 3'd3;
  localparam logic [2:0] S_NMI_SVC  = 3'd4;
`ifdef NMI_NESTING_EN
  localparam logic [2:0] S_NMI_NEST = 3'd5;
`endif

  logic [2:0]    state;
  logic [CW-1:0] ack_cnt;
  logic          kind_nmi;
  logic          nmi_prev;
  logic          nmi_pend;
  logic          nmi_edge;
  logic          nmi_req;
  logic          int_req;
  logic          take_now;
  logic          take_nmi;
  logic          ret_now;
`ifdef NMI_NESTING_EN
  logic          nested;
  logic [31:0]   epc_int;
`endif

  assign nmi_edge = NMI & ~nmi_prev;
  // An edge arriving in the boundary cycle itself counts as pending.
  assign nmi_req  = nmi_pend | nmi_edge;
  assign int_req  = INT & ~INTD;
  assign ret_now  = instr_boundary & eret;

  // Take decision; NMI beats INT, a return beats a nesting preemption.
  always_comb begin
    take_now = 1'b0;
    take_nmi = 1'b0;
    if (state == S_IDLE && instr_boundary) begin
      if (nmi_req) begin
        take_now = 1'b1;
        take_nmi = 1'b1;
      end else if (int_req) begin
        take_now = 1'b1;
      end
    end
`ifdef NMI_NESTING_EN
    if (state == S_INT_SVC && instr_boundary && !eret && nmi_req) begin
      take_now = 1'b1;
      take_nmi = 1'b1;
    end
`endif
  end

  assign hold     = take_now | (state == S_ACK) | (state == S_ENTER);
  assign take_irq = (state == S_ENTER);
  assign vector   = take_irq ? (kind_nmi ? VEC_NMI : VEC_INT) : 32'h0;
  assign INA      = (state == S_ACK);

`ifdef NMI_NESTING_EN
  assign in_handler = {(state == S_NMI_SVC) | (state == S_NMI_NEST),
                       (state == S_INT_SVC) | (state == S_NMI_NEST)};
`else
  assign in_handler = {(state == S_NMI_SVC), (state == S_INT_SVC)};
`endif

  // NMI sampler runs through reset so a level held across release is no edge.
  always_ff @(posedge clk) begin
    nmi_prev <= NMI;
  end

  // Sequencer state, ACK down-counter, pending NMI and EPC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ack_cnt  <= '0;
      kind_nmi <= 1'b0;
      nmi_pend <= 1'b0;
      epc      <= 32'h0;
`ifdef NMI_NESTING_EN
      nested   <= 1'b0;
      epc_int  <= 32'h0;
`endif
    end else begin
      if (take_now && take_nmi) nmi_pend <= 1'b0;
      else if (nmi_edge)        nmi_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (take_now) begin
            state    <= S_ACK;
            ack_cnt  <= ACK_LOAD;
            kind_nmi <= take_nmi;
            epc      <= pc_next;
`ifdef NMI_NESTING_EN
            nested   <= 1'b0;
`endif
          end
        end
        S_ACK: begin
          if (ack_cnt == '0) state <= S_ENTER;
          else               ack_cnt <= ack_cnt - CW'(1);
        end
        S_ENTER: begin
`ifdef NMI_NESTING_EN
          if (kind_nmi) state <= nested ? S_NMI_NEST : S_NMI_SVC;
          else          state <= S_INT_SVC;
`else
          state <= kind_nmi ? S_NMI_SVC : S_INT_SVC;
`endif
        end
        S_INT_SVC: begin
          if (ret_now) begin
            state <= S_IDLE;
`ifdef NMI_NESTING_EN
          end else if (take_now) begin
            state    <= S_ACK;
            ack_cnt  <= ACK_LOAD;
            kind_nmi <= 1'b1;
            nested   <= 1'b1;
            epc_int  <= epc;
            epc      <= pc_next;
`endif
          end
        end
        S_NMI_SVC: begin
          if (ret_now) state <= S_IDLE;
        end
`ifdef NMI_NESTING_EN
        S_NMI_NEST: begin
          if (ret_now) begin
            state  <= S_INT_SVC;
            epc    <= epc_int;
            nested <= 1'b0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

- Sequences external interrupts into the multi-cycle processor.
- Edge-detects `NMI`, samples the level `INT` against the `INTD` mask, and arbitrates NMI over INT.
- Only at instruction boundaries reported by the controller: holds the controller, drives the `INA` acknowledge, captures the return PC, and issues a one-cycle redirect to the handler vector.
- Sits between the interrupt pins and the controller/datapath; replaces ad-hoc interrupt handling inside the controller.

## Interface
Parameters:
- `VEC_INT`, 32'h0000_0080, INT handler address
- `VEC_NMI`, 32'h0000_0100, NMI handler address
- `ACK_CYCLES`, 2, width of `INA` pulse in cycles (≥1)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `INT`  in  1  maskable interrupt request, level, held until `INA`
- `NMI`  in  1  non-maskable interrupt, rising-edge sensitive
- `INTD`  in  1  interrupt disable; masks `INT` only
- `instr_boundary`  in  1  controller is at fetch; previous instruction retired
- `eret`  in  1  return-from-interrupt retired; qualified by `instr_boundary`
- `pc_next`  in  32  PC of the next instruction to fetch
- `hold`  out  1  controller must not start fetch this cycle
- `take_irq`  out  1  one-cycle redirect strobe; PC ← `vector`
- `vector`  out  32  handler address; valid while `take_irq`
- `epc`  out  32  return address for the current handler level
- `INA`  out  1  interrupt acknowledge to the external device
- `in_handler`  out  2  {NMI active, INT active}

## Operation
- NMI edge detector: `nmi_prev` ← `NMI` every cycle, including during reset. `nmi_pend` is set on `NMI & ~nmi_prev` and cleared on the cycle the NMI is taken. Asserting `NMI` through reset release produces no edge.
- States: IDLE, ACK, ENTER, INT_SVC, NMI_SVC, NMI_NEST (exists only with the macro).
- IDLE, on `instr_boundary`:
  - `nmi_pend` → ACK as NMI.
  - else `INT & ~INTD` → ACK as INT.
  - else stay in IDLE.
  - On a take, `epc` ← `pc_next`, and `hold` is asserted combinationally in that same cycle.
- ACK: `INA`=1 for exactly `ACK_CYCLES` cycles (down-counter), `hold`=1, then → ENTER. Interrupt kind is latched; input changes during ACK are ignored.
- ENTER: `take_irq`=1, `vector` = `VEC_NMI`/`VEC_INT`, `hold`=1 for that single cycle, then → NMI_SVC or INT_SVC.
- INT_SVC: further INT is not accepted (no INT nesting).
  - `instr_boundary & eret` → IDLE.
  - Handling of a pending NMI is set by the macro.
- NMI_SVC: `instr_boundary & eret` → IDLE. INT and new NMI edges are held pending (`nmi_pend` stays set); they are evaluated at the first boundary after the return.
- `eret` outside a handler state is ignored; `epc` is unchanged.
- `in_handler`: bit0=1 in INT_SVC, and in NMI_NEST when the macro is enabled; bit1=1 in NMI_SVC/NMI_NEST.
- Simultaneous events:
  - NMI edge in the same cycle as `eret` in INT_SVC: the return completes first, and NMI is taken at the next boundary.
  - `eret` and an NMI edge in the same IDLE-boundary cycle: NMI is taken.

## Timing
- Reset values: `hold`=0, `take_irq`=0, `vector`=0, `epc`=0, `INA`=0, `in_handler`=0; state IDLE; `nmi_pend`=0.
- Reset mid-sequence aborts to IDLE next cycle; saved EPCs are cleared.
- Latency from a qualifying boundary (cycle N):
  - `INA` high in cycles N+1 .. N+`ACK_CYCLES`.
  - `take_irq` in cycle N+`ACK_CYCLES`+1.
  - Service state from N+`ACK_CYCLES`+2.
- `hold` is high for cycles N .. N+`ACK_CYCLES`+1 inclusive.
- `epc` is registered and stable from N+1 until the next take or return.

## Configuration
- `NMI_NESTING_EN` defined:
  - In INT_SVC, a pending NMI at `instr_boundary` preempts the INT handler.
  - The INT `epc` is pushed to a second register, and the full ACK/ENTER sequence runs into NMI_NEST.
  - `eret` in NMI_NEST → INT_SVC, with `epc` restored to the saved INT return address.
- `NMI_NESTING_EN` undefined:
  - NMI_NEST and the second EPC register are removed.
  - NMI stays pending during INT_SVC and is taken at the first boundary after the INT `eret`.

## Test plan
- Reset with `NMI`=1, release, hold `NMI` high, pulse `instr_boundary` → no `INA`, no `take_irq`, `in_handler`=0.
- `INT`=1, `INTD`=0, boundary with `pc_next`=0x40 → `INA` high 2 cycles, `take_irq` with `vector`=0x80, `epc`=0x40. Then `eret`+boundary → IDLE, `in_handler`=0.
- `INT`=1, `INTD`=1, 5 boundaries → no take. Then NMI edge + boundary with `pc_next`=0x200 → `vector`=0x100, `epc`=0x200.
- INT and NMI edge pending at the same boundary → NMI taken first. After its `eret`, INT (still high) is taken at the next boundary.
- In INT_SVC (`epc`=0x40): NMI edge, boundary with `pc_next`=0x84.
  - With `NMI_NESTING_EN`: `vector`=0x100, `epc`=0x84. `eret` → INT_SVC with `epc`=0x40.
  - Without: no take until the INT `eret`.
- Reset asserted during ACK → `INA`=0 and `hold`=0 next cycle, state IDLE, no `take_irq`.
